// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Handshake bundle for the iterative AES-128 encryption sequencer.
//   in_valid / in_ready / in_data    : plaintext block offer (byte 0 at [127:120])
//   out_valid / out_ready / out_data : ciphertext delivery  (byte 0 at [127:120])
// Modport 'slave' is the sequencer side, 'master' is the producer/consumer side.
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES-128 encryption sequencer. Accepts one plaintext block, runs
// the initial AddRoundKey, nine full rounds and the final round on
// consecutive cycles through one shared round datapath, then holds the
// ciphertext until the consumer takes it.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        handshake bundle (slave side): in_valid/in_ready/in_data,
//              out_valid/out_ready/out_data
//   key_words  expanded key schedule, round key k at [1407-128k -: 128]
//   busy       high while a block is in flight or waiting to be consumed
//   round      round counter: 0 idle, 1..9 rounds, 10 final/done
// Parameter:
//   REG_KEY    1: capture key_words on accept; 0: use key_words live
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter bit REG_KEY = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   aes_round_ctrl_if.slave  bus,
   input  logic [1407:0]    key_words,
   output logic             busy,
   output logic [3:0]       round
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // GF(2^8) multiply by x modulo the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product, shift-and-add
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p_v;
      logic [7:0] a_v;
      p_v = 8'h00;
      a_v = a;
      for (int i = 0; i < 32'sd8; i++) begin
         if (b[i]) p_v = p_v ^ a_v;
         else      p_v = p_v;
         a_v = xtime(a_v);
      end
      return p_v;
   endfunction

   // S-box: multiplicative inverse (x^254, zero maps to zero) then affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv_v;
      inv_v = x;
      // x -> x^3 -> x^7 -> ... -> x^127
      for (int i = 0; i < 32'sd6; i++) begin
         inv_v = gf_mul(gf_mul(inv_v, inv_v), x);
      end
      inv_v = gf_mul(inv_v, inv_v);
      return inv_v ^ {inv_v[6:0], inv_v[7]}   ^ {inv_v[5:0], inv_v[7:6]}
                   ^ {inv_v[4:0], inv_v[7:5]} ^ {inv_v[3:0], inv_v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r_v;
      r_v = '0;
      for (int n = 0; n < 32'sd16; n++) begin
         r_v[n*32'sd8 +: 8] = sbox(s[n*32'sd8 +: 8]);
      end
      return r_v;
   endfunction

   // Row w of column c takes the byte from column (c+w) mod 4
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r_v;
      r_v = '0;
      for (int c = 0; c < 32'sd4; c++) begin
         for (int w = 0; w < 32'sd4; w++) begin
            r_v[32'sd127 - 32'sd8*(32'sd4*c + w) -: 8] =
               s[32'sd127 - 32'sd8*(32'sd4*((c + w) % 32'sd4) + w) -: 8];
         end
      end
      return r_v;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r_v;
      logic [7:0]   a0, a1, a2, a3;
      r_v = '0;
      for (int c = 0; c < 32'sd4; c++) begin
         a0 = s[32'sd127 - 32'sd32*c -: 8];
         a1 = s[32'sd119 - 32'sd32*c -: 8];
         a2 = s[32'sd111 - 32'sd32*c -: 8];
         a3 = s[32'sd103 - 32'sd32*c -: 8];
         r_v[32'sd127 - 32'sd32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
         };
      end
      return r_v;
   endfunction

   state_t         state_r;
   logic [127:0]   st_r;
   logic [127:0]   out_data_r;
   logic           out_valid_r;
   logic           in_ready_r;
   logic           busy_r;
   logic [3:0]     round_r;

   logic [1407:0]  key_use_s;
   logic [127:0]   rk_a_s [0:10];
   logic [127:0]   rk_s;
   logic [127:0]   round_out_s;
   logic [127:0]   final_out_s;
   logic           accept_s;

   assign accept_s = (state_r == S_IDLE) && bus.in_valid && in_ready_r;

   generate
      if (REG_KEY) begin : g_key_reg
         logic [1407:0] key_r;
         // Schedule snapshot taken on the accept edge so later key changes cannot disturb the block
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        key_r <= '0;
            else if (accept_s) key_r <= key_words;
            else               key_r <= key_r;
         end
         assign key_use_s = key_r;
      end else begin : g_key_live
         assign key_use_s = key_words;
      end
   endgenerate

   for (genvar k = 0; k < 11; k++) begin : g_rk
      assign rk_a_s[k] = key_use_s[32'sd1407 - 32'sd128*k -: 128];
   end

   // Round key for the round currently being applied
   always_comb begin
      rk_s = '0;
      if (round_r <= 4'd10) rk_s = rk_a_s[round_r];
      else                  rk_s = '0;
   end

   assign round_out_s = mix_columns(shift_rows(sub_bytes(st_r))) ^ rk_s;
   assign final_out_s = shift_rows(sub_bytes(st_r)) ^ rk_a_s[10];

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         st_r        <= '0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         round_r     <= 4'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  // Round-0 key is taken live: the snapshot lands on this same edge
                  st_r       <= bus.in_data ^ key_words[1407:1280];
                  round_r    <= 4'd1;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= S_ROUND;
               end else begin
                  state_r    <= S_IDLE;
               end
            end
            S_ROUND: begin
               st_r    <= round_out_s;
               round_r <= round_r + 4'd1;
               if (round_r == 4'd9) state_r <= S_FINAL;
               else                 state_r <= S_ROUND;
            end
            S_FINAL: begin
               st_r        <= final_out_s;
               out_data_r  <= final_out_s;
               out_valid_r <= 1'b1;
               state_r     <= S_DONE;
            end
            S_DONE: begin
               if (out_valid_r && bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  round_r     <= 4'd0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= S_IDLE;
               end else begin
                  state_r     <= S_DONE;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               round_r     <= 4'd0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign busy          = busy_r;
   assign round         = round_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl (REG_KEY = 1). A cycle-level
// transaction model (busy flag, cycles since accept, expected ciphertext from
// a byte-matrix AES reference) is compared against every DUT output on each
// falling edge. FIPS-197 vectors pin the reference and the DUT results.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [1407:0] key_words;
   logic          busy;
   logic [3:0]    round;

   aes_round_ctrl_if bus ();

   aes_round_ctrl #(.REG_KEY(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .key_words (key_words),
      .busy      (busy),
      .round     (round)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;
   logic [7:0] sbox_t [256];

   // reference model state
   bit           m_busy;
   int           m_age;
   bit           m_ov;
   logic [127:0] m_od;
   logic [127:0] m_exp;
   int           m_acc_n = 0;
   int           m_acc_cyc = 0;
   int           m_con_cyc = 0;
   logic [127:0] got_q [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // byte at row r, column c of the state matrix
   function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
      return s[127 - 8*(r + 4*c) -: 8];
   endfunction

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rcon [10];
      logic [1407:0] kw;
      rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      for (int i = 0; i < 44; i++) begin
         if (i < 4) w[i] = key[127 - 32*i -: 32];
         else begin
            t = w[i-1];
            if (i % 4 == 0) begin
               t = {t[23:0], t[31:24]};
               t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
               t = t ^ {rcon[i/4 - 1], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
         end
         kw[1407 - 32*i -: 32] = w[i];
      end
      return kw;
   endfunction

   // AES state after AddRoundKey(rk0) and rounds 1..upto (upto = 10 gives the ciphertext)
   function automatic logic [127:0] aes_rounds(input logic [127:0] pt, input logic [1407:0] kw, input int upto);
      logic [127:0] s, t, u;
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      s = pt ^ kw[1407 -: 128];
      for (int rd = 1; rd <= upto; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[127 - 8*(r + 4*c) -: 8] = sbox_t[gb(s, r, (c + r) % 4)];
         if (rd != 10) begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  acc = 8'h00;
                  for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], gb(t, k, c));
                  u[127 - 8*(r + 4*c) -: 8] = acc;
               end
            t = u;
         end
         s = t ^ kw[1407 - 128*rd -: 128];
      end
      return s;
   endfunction

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // transaction-level reference: idle -> busy for 10 cycles -> hold until consumed
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_age <= 0; m_ov <= 1'b0; m_od <= '0; m_exp <= '0;
      end else if (!m_busy) begin
         if (bus.in_valid) begin
            m_busy    <= 1'b1;
            m_age     <= 0;
            m_exp     <= aes_rounds(bus.in_data, key_words, 10);
            m_acc_n   <= m_acc_n + 1;
            m_acc_cyc <= cyc;
         end
      end else if (m_ov) begin
         if (bus.out_ready) begin
            m_busy    <= 1'b0;
            m_ov      <= 1'b0;
            m_con_cyc <= cyc;
            got_q.push_back(bus.out_data);
         end
      end else begin
         m_age <= m_age + 1;
         if (m_age == 9) begin
            m_ov <= 1'b1;
            m_od <= m_exp;
         end
      end
   end

   // per-cycle comparison of every DUT output against the reference
   always @(negedge clk) begin
      logic [3:0] exp_round;
      exp_round = !m_busy ? 4'd0 : (m_age >= 9 ? 4'd10 : 4'(m_age + 1));
      if (chk_en) begin
         chk("in_ready",  bus.in_ready,  !m_busy);
         chk("out_valid", bus.out_valid, m_ov);
         chk("busy",      busy,          m_busy);
         chk("round",     round,         exp_round);
         chk("out_data",  bus.out_data,  m_od);
      end
   end

   task automatic wait_acc(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (m_acc_n >= target) ok = 1'b1;
      end
      chk("accept_timeout", ok, 1'b1);
   endtask

   task automatic wait_got(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (got_q.size() >= target) ok = 1'b1;
      end
      chk("consume_timeout", ok, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_data"},  bus.out_data,  128'h0);
      chk({tag, "_busy"},      busy,          1'b0);
      chk({tag, "_round"},     round,         4'd0);
   endtask

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   initial begin
      logic [1407:0] kw_c1, kw_b;
      logic [127:0]  p, q, exp_p;
      logic [7:0]    inv, b;
      int            n0, nc, a1, a2;

      // S-box from its definition: brute-force inverse, then the FIPS affine map
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
         sbox_t[x] = b;
      end

      rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; key_words = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      chk_en = 1'b1;

      // pin the reference with FIPS-197 intermediate values
      kw_c1 = expand(C1_KEY);
      kw_b  = expand(B_KEY);
      chk("model_rk10_B", kw_b[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("model_c1_r0", aes_rounds(C1_PT, kw_c1, 0), 128'h00102030405060708090a0b0c0d0e0f0);
      chk("model_c1_r1", aes_rounds(C1_PT, kw_c1, 1), 128'h89d810e8855ace682d1843d8cb128fe4);
      chk("model_c1_ct", aes_rounds(C1_PT, kw_c1, 10), C1_CT);
      chk("model_b_ct",  aes_rounds(B_PT, kw_b, 10), B_CT);

      // C.1 then B back-to-back with out_ready high
      bus.out_ready = 1'b1;
      n0 = m_acc_n; nc = got_q.size();
      bus.in_valid = 1'b1; bus.in_data = C1_PT; key_words = kw_c1;
      wait_acc(n0 + 1); a1 = m_acc_cyc;
      bus.in_data = B_PT; key_words = kw_b;
      wait_acc(n0 + 2); a2 = m_acc_cyc;
      bus.in_valid = 1'b0;
      chk("b2b_period", 128'(a2 - a1), 128'd12);
      wait_got(nc + 2);
      chk("c1_out_data", got_q[nc], C1_CT);
      chk("b_out_data",  got_q[nc+1], B_CT);

      // backpressure: hold out_ready low in DONE while a second block is offered
      bus.out_ready = 1'b0;
      n0 = m_acc_n; nc = got_q.size();
      p = {$urandom, $urandom, $urandom, $urandom};
      q = {$urandom, $urandom, $urandom, $urandom};
      exp_p = aes_rounds(p, kw_c1, 10);
      bus.in_valid = 1'b1; bus.in_data = p; key_words = kw_c1;
      wait_acc(n0 + 1);
      bus.in_data = q;
      for (int i = 0; i < 30 && !m_ov; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_data", bus.out_data, exp_p);
         chk("bp_in_ready", bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      wait_acc(n0 + 2);
      chk("bp_accept_after_consume", 128'(m_acc_cyc), 128'(m_con_cyc + 1));
      bus.in_valid = 1'b0;
      wait_got(nc + 2);
      chk("bp_first_result", got_q[nc], exp_p);

      // reset at E5: everything returns to reset values at once, no out_valid
      n0 = m_acc_n; nc = got_q.size();
      bus.in_valid = 1'b1; bus.in_data = C1_PT; key_words = kw_c1;
      wait_acc(n0 + 1);
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midreset");
      @(negedge clk) rst_n = 1'b1;
      repeat (14) @(negedge clk);
      chk("midreset_no_output", 128'(got_q.size()), 128'(nc));
      bus.in_valid = 1'b1;
      wait_acc(n0 + 2);
      bus.in_valid = 1'b0;
      wait_got(nc + 1);
      chk("after_reset_c1", got_q[nc], C1_CT);

      // key stability: schedule overwritten with all-ones by E2
      n0 = m_acc_n; nc = got_q.size();
      bus.in_valid = 1'b1; bus.in_data = C1_PT; key_words = kw_c1;
      wait_acc(n0 + 1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      key_words = '1;
      wait_got(nc + 1);
      chk("regkey_c1", got_q[nc], C1_CT);

      // randomized traffic: random offers, keys and backpressure
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         bus.in_valid  = ($urandom_range(0, 1) == 1);
         bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0)
            for (int k = 0; k < 44; k++) key_words[k*32 +: 32] = $urandom;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("random_blocks_seen", 128'(m_acc_n > n0 + 5), 128'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
